// File: rtl/bp_fe_queue_rollback_fifo_pkg.sv
// Shared configuration for the FE->BE rollback queue: processor configs and
// the fe_queue packet width each of them implies.
package bp_fe_queue_rollback_fifo_pkg;

  typedef enum logic [0:0] {
    e_bp_inv_cfg     = 1'b0,
    e_bp_default_cfg = 1'b1
  } bp_params_e;

  // Packet width is the flattened fe_queue struct for the chosen config.
  function automatic int fe_queue_width_f(input bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? 119 : 32;
  endfunction

endpackage

// File: rtl/bp_fe_queue_rollback_fifo_mem.sv
// One-write, one-asynchronous-read storage array for queue packets.
module bp_fe_queue_rollback_fifo_mem
  #(parameter int width_p = 32,
    parameter int els_p = 8,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1)
  (input  logic                     clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic                     r_v_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o);

  logic [width_p-1:0] mem [els_p];

  // Data storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_v_i)
      mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

  if (read_write_same_addr_p == 0) begin : g_no_rw_same
    no_rw_same_addr : assert property (@(posedge clk_i)
      !(w_v_i && r_v_i && (w_addr_i == r_addr_i)));
  end

endmodule

// File: rtl/bp_fe_queue_rollback_fifo.sv
// Checkpointed FE->BE queue: read entries are held until committed (deq),
// can be replayed (roll), and unread entries can be discarded (clr).
module bp_fe_queue_rollback_fifo
  import bp_fe_queue_rollback_fifo_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int els_p = 8,
    localparam int fe_queue_width_lp = fe_queue_width_f(bp_params_p))
  (input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [fe_queue_width_lp-1:0] fe_queue_i,
   input  logic                         fe_queue_v_i,
   output logic                         fe_queue_ready_o,
   output logic [fe_queue_width_lp-1:0] fe_queue_o,
   output logic                         fe_queue_v_o,
   input  logic                         fe_queue_yumi_i,
   input  logic                         fe_queue_deq_i,
   input  logic                         fe_queue_roll_i,
   input  logic                         fe_queue_clr_i,
   output logic                         empty_o);

  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int ptr_width_lp  = addr_width_lp + 1;

  // Handshakes: enqueue fires on fe_queue_v_i & fe_queue_ready_o; the BE may
  // only assert fe_queue_yumi_i while fe_queue_v_o is high, and only deq when
  // at least one read entry is uncommitted.
  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_e, rptr_y, cptr_n, rptr_n, wptr_n;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    enq;

  assign occupancy        = wptr - cptr;
  assign fe_queue_ready_o = (occupancy != ptr_width_lp'(els_p));
  assign fe_queue_v_o     = (rptr != wptr);
  assign empty_o          = (wptr == cptr);
  assign enq              = fe_queue_v_i & fe_queue_ready_o;

  // Order matters: the rewind target is the post-commit pointer, and clr
  // snaps the write pointer onto the post-roll read pointer.
  assign cptr_n = cptr + ptr_width_lp'(fe_queue_deq_i);
  assign rptr_y = rptr + ptr_width_lp'(fe_queue_yumi_i);
  assign wptr_e = wptr + ptr_width_lp'(enq);
  assign rptr_n = fe_queue_roll_i ? cptr_n : rptr_y;
  assign wptr_n = fe_queue_clr_i  ? rptr_n : wptr_e;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  bp_fe_queue_rollback_fifo_mem
    #(.width_p(fe_queue_width_lp), .els_p(els_p), .read_write_same_addr_p(0))
    mem
     (.clk_i   (clk_i),
      .w_v_i   (enq),
      .w_addr_i(wptr[addr_width_lp-1:0]),
      .w_data_i(fe_queue_i),
      .r_v_i   (fe_queue_v_o),
      .r_addr_i(rptr[addr_width_lp-1:0]),
      .r_data_o(fe_queue_o));

  yumi_without_valid : assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  deq_without_read : assert property (@(posedge clk_i) disable iff (reset_i)
    fe_queue_deq_i |-> (cptr != rptr));

endmodule

// File: tb/tb_bp_fe_queue_rollback_fifo.sv
// Directed bench for the rollback queue: a fill/drain vector table plus
// hand-written roll/clr/wrap/reset sequences.
module tb_bp_fe_queue_rollback_fifo;
  import bp_fe_queue_rollback_fifo_pkg::*;

  localparam int W   = fe_queue_width_f(e_bp_inv_cfg);
  localparam int ELS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d_in = '0;
  logic         v_in = 1'b0, yumi = 1'b0, deq = 1'b0, roll = 1'b0, clr = 1'b0;
  logic         ready, v_out, empty;
  logic [W-1:0] d_out;

  int tests = 0;
  int fails = 0;

  bp_fe_queue_rollback_fifo #(.bp_params_p(e_bp_inv_cfg), .els_p(ELS)) dut
    (.clk_i(clk), .reset_i(rst), .fe_queue_i(d_in), .fe_queue_v_i(v_in),
     .fe_queue_ready_o(ready), .fe_queue_o(d_out), .fe_queue_v_o(v_out),
     .fe_queue_yumi_i(yumi), .fe_queue_deq_i(deq), .fe_queue_roll_i(roll),
     .fe_queue_clr_i(clr), .empty_o(empty));

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         yumi, deq, roll, clr;
    logic         e_ready, e_v, e_empty, chk_d;
    logic [W-1:0] e_d;
  } vec_t;

  vec_t vecs[18];

  // Held entries (oldest committed-pending first) for the random wrap run.
  logic [W-1:0] exp_q[$];
  int           rd;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic e_ready, input logic e_v, input logic e_empty);
    check({name, ".ready"}, W'(ready), W'(e_ready));
    check({name, ".v"},     W'(v_out), W'(e_v));
    check({name, ".empty"}, W'(empty), W'(e_empty));
  endtask

  // Called at a negedge; applies inputs across one posedge and returns at
  // the following negedge with inputs idle.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                     input logic dq, input logic rl, input logic cl);
    v_in = v; d_in = d; yumi = y; deq = dq; roll = rl; clr = cl;
    @(posedge clk);
    @(negedge clk);
    v_in = 1'b0; yumi = 1'b0; deq = 1'b0; roll = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  accepted;
    int  budget;
    logic acc, ry, rdq, rrl, rcl;
    logic [W-1:0] rnd;

    // Fill with 1..8, read the first, then read+commit the rest.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{v: 1'b1, d: W'(i + 1), yumi: 1'b0, deq: 1'b0, roll: 1'b0, clr: 1'b0,
                  e_ready: 1'b1, e_v: (i > 0), e_empty: (i == 0), chk_d: (i > 0), e_d: W'(1)};
    vecs[8] = '{v: 1'b0, d: '0, yumi: 1'b1, deq: 1'b0, roll: 1'b0, clr: 1'b0,
                e_ready: 1'b0, e_v: 1'b1, e_empty: 1'b0, chk_d: 1'b1, e_d: W'(1)};
    for (int j = 1; j < 8; j++)
      vecs[8 + j] = '{v: 1'b0, d: '0, yumi: 1'b1, deq: 1'b1, roll: 1'b0, clr: 1'b0,
                      e_ready: (j >= 2), e_v: 1'b1, e_empty: 1'b0, chk_d: 1'b1, e_d: W'(j + 1)};
    vecs[16] = '{v: 1'b0, d: '0, yumi: 1'b0, deq: 1'b1, roll: 1'b0, clr: 1'b0,
                 e_ready: 1'b1, e_v: 1'b0, e_empty: 1'b0, chk_d: 1'b0, e_d: '0};
    vecs[17] = '{v: 1'b0, d: '0, yumi: 1'b0, deq: 1'b0, roll: 1'b0, clr: 1'b0,
                 e_ready: 1'b1, e_v: 1'b0, e_empty: 1'b1, chk_d: 1'b0, e_d: '0};

    do_reset();
    @(negedge clk);
    check_status("reset", 1'b1, 1'b0, 1'b1);

    foreach (vecs[k]) begin
      check_status($sformatf("fill_drain[%0d]", k), vecs[k].e_ready, vecs[k].e_v, vecs[k].e_empty);
      if (vecs[k].chk_d) check($sformatf("fill_drain[%0d].data", k), d_out, vecs[k].e_d);
      cyc(vecs[k].v, vecs[k].d, vecs[k].yumi, vecs[k].deq, vecs[k].roll, vecs[k].clr);
    end

    // Roll replay: A,B read, A committed, rewind -> B then C.
    do_reset();
    @(negedge clk);
    cyc(1, W'('hA1), 0, 0, 0, 0);
    cyc(1, W'('hB2), 0, 0, 0, 0);
    cyc(1, W'('hC3), 0, 0, 0, 0);
    check("roll.first", d_out, W'('hA1));
    cyc(0, '0, 1, 0, 0, 0);
    check("roll.second", d_out, W'('hB2));
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    check_status("roll.before_roll", 1'b1, 1'b1, 1'b0);
    cyc(0, '0, 0, 0, 1, 0);
    check_status("roll.after_roll", 1'b1, 1'b1, 1'b0);
    check("roll.replay_b", d_out, W'('hB2));
    cyc(0, '0, 1, 0, 0, 0);
    check("roll.replay_c", d_out, W'('hC3));
    cyc(0, '0, 1, 0, 0, 0);
    check_status("roll.drained", 1'b1, 1'b0, 1'b0);

    // Clr keeps read-but-uncommitted entries for a later roll.
    do_reset();
    @(negedge clk);
    cyc(1, W'('hA1), 0, 0, 0, 0);
    cyc(1, W'('hB2), 0, 0, 0, 0);
    cyc(1, W'('hC3), 0, 0, 0, 0);
    cyc(1, W'('hD4), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1);
    check_status("clr.after_clr", 1'b1, 1'b0, 1'b0);
    cyc(0, '0, 0, 0, 1, 0);
    check_status("clr.after_roll", 1'b1, 1'b1, 1'b0);
    check("clr.replay_a", d_out, W'('hA1));
    cyc(0, '0, 1, 0, 0, 0);
    check("clr.replay_b", d_out, W'('hB2));
    cyc(0, '0, 1, 0, 0, 0);
    check("clr.no_c", W'(v_out), W'(0));
    cyc(1, W'('hE5), 0, 0, 0, 0);
    check("clr.e_follows_b", d_out, W'('hE5));
    check("clr.e_valid", W'(v_out), W'(1));

    // Clr+roll with a same-cycle enqueue empties the queue; X is dropped.
    do_reset();
    @(negedge clk);
    cyc(1, W'('hA1), 0, 0, 0, 0);
    cyc(1, W'('hB2), 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0);
    cyc(1, W'('h5A5A), 0, 0, 1, 1);
    check_status("clrroll", 1'b1, 1'b0, 1'b1);
    cyc(0, '0, 0, 0, 0, 0);
    check_status("clrroll.idle", 1'b1, 1'b0, 1'b1);
    cyc(1, W'('h77), 0, 0, 0, 0);
    check("clrroll.next_pkt", d_out, W'('h77));

    // Random yumi/deq/roll/clr with FE valid held high, across pointer wrap.
    do_reset();
    @(negedge clk);
    exp_q.delete();
    rd = 0;
    accepted = 0;
    budget = 0;
    while (accepted < 3 * ELS && budget < 2000) begin
      check_status($sformatf("wrap[%0d]", budget), (exp_q.size() < ELS), (rd < exp_q.size()), (exp_q.size() == 0));
      if (rd < exp_q.size()) check($sformatf("wrap[%0d].data", budget), d_out, exp_q[rd]);
      rnd = W'($urandom);
      ry  = (rd < exp_q.size()) && ($urandom_range(0, 1) == 1);
      rdq = (rd > 0) && ($urandom_range(0, 2) != 0);
      rrl = ($urandom_range(0, 9) == 0);
      rcl = ($urandom_range(0, 19) == 0);
      acc = (exp_q.size() < ELS);
      if (rdq) begin void'(exp_q.pop_front()); rd--; end
      if (rrl) rd = 0;
      else if (ry) rd++;
      if (acc) begin exp_q.push_back(rnd); accepted++; end
      if (rcl) while (exp_q.size() > rd) void'(exp_q.pop_back());
      cyc(1'b1, rnd, ry, rdq, rrl, rcl);
      budget++;
    end
    tests++;
    if (accepted < 3 * ELS) begin
      fails++;
      $display("FAIL wrap.budget: accepted %0d, required %0d", accepted, 3 * ELS);
    end

    // Asynchronous reset between edges drops everything at once.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) cyc(1, W'(i + 'h10), 0, 0, 0, 0);
    check_status("areset.before", 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_status("areset.during", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("areset.after", 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
